// File: rtl/csi_pkg.sv
// csi_pkg: shared definitions for the CSI-2 packet decoder.
//   - data type constants for the short sync packets and RAW8
//   - FSM state encoding
//   - ecc6(): 6-bit header Hamming code over bytes B0..B2
//   - crc16_byte(): one byte of the payload CRC (poly 0x1021 reflected, LSB first)
package csi_pkg;

  localparam logic [5:0]  DT_FS       = 6'h00;
  localparam logic [5:0]  DT_FE       = 6'h01;
  localparam logic [5:0]  DT_LS       = 6'h02;
  localparam logic [5:0]  DT_LE       = 6'h03;
  localparam logic [5:0]  DT_RAW8     = 6'h2A;
  // Data types below this value are short packets (no payload).
  localparam logic [5:0]  DT_LONG_MIN = 6'h10;

  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_R  = 16'h8408;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_CHECK,
    ST_PAYLOAD,
    ST_CRC
  } state_e;

  // Each parity bit is the XOR of the header bits selected by its mask
  // (d[7:0]=B0, d[15:8]=B1, d[23:16]=B2).
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY_R;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/csi_crc16.sv
// csi_crc16: payload CRC accumulator, two bytes per cycle.
//   clk_i, rst_i   clock, async active-high reset (crc -> FFFF)
//   clr_i          reload FFFF (takes priority over en_i)
//   en_i           fold data_i into the CRC, byte [7:0] first then [15:8]
//   data_i         two payload bytes
//   crc_o          current CRC value
module csi_crc16
  import csi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = CRC_INIT;
    else if (en_i) crc_d = crc16_byte(crc16_byte(crc_q, data_i[7:0]), data_i[15:8]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/csi_packet_decoder.sv
// csi_packet_decoder: CSI-2 packet parser for a 2-lane byte-merged stream.
//   mipi_clk, reset        byte clock, async active-high reset
//   rx_stop                burst ended/aborted: return to IDLE
//   pkt_start              next valid word carries header bytes 0,1
//   in_valid, in_data      {lane1 byte, lane0 byte}, lane0 is earlier
//   frame_start/frame_end  FS/FE short packet strobes
//   line_start/line_end    LS/LE short packets or first/last RAW8 word
//   pix_valid/pix_data/pix_x  RAW8 pixel pair and x of pix_data[7:0]
//   ecc_err/crc_err/fmt_err   single-cycle error pulses
// All outputs are registered.
module csi_packet_decoder
  import csi_pkg::*;
#(
  parameter int         MAX_WC  = 4096,
  parameter logic [5:0] RAW8_DT = DT_RAW8,
  parameter logic [1:0] VC_SEL  = 2'd0
) (
  input  logic        mipi_clk,
  input  logic        reset,
  input  logic        rx_stop,
  input  logic        pkt_start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [11:0] pix_x,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        fmt_err
);

  localparam logic [15:0] MAX_WC_W = 16'(MAX_WC);

  state_e      state_q, state_d;
  state_e      tgt_q, tgt_d;     // where CHECK resolves to
  state_e      act;              // state whose word handling applies this cycle
  logic [7:0]  di_q, di_d;
  logic [7:0]  wc_lo_q, wc_lo_d;
  logic [14:0] nwords_q, nwords_d;
  logic [14:0] cnt_q, cnt_d;
  logic        pix_en_q, pix_en_d;

  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic        pv_q, pv_d;
  logic [15:0] pd_q, pd_d;
  logic [11:0] px_q, px_d;
  logic        ecc_q, ecc_d, crc_q, crc_d, fmt_q, fmt_d;

  logic        crc_clr, crc_en;
  logic [15:0] crc_val;

  logic [15:0] hdr_wc;
  logic [5:0]  hdr_dt;
  logic        vc_ok, ecc_ok, last_word, mid_pkt;

  csi_crc16 u_crc (
    .clk_i  (mipi_clk),
    .rst_i  (reset),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (in_data),
    .crc_o  (crc_val)
  );

  // CHECK only holds the registered header verdict for one cycle. A word that
  // arrives while in CHECK is handled as if the FSM were already in the target
  // state, so a payload word directly after the header is not lost.
  assign act       = (state_q == ST_CHECK) ? tgt_q : state_q;
  assign hdr_wc    = {in_data[7:0], wc_lo_q};
  assign hdr_dt    = di_q[5:0];
  assign vc_ok     = (di_q[7:6] == VC_SEL);
  assign ecc_ok    = (in_data[15:8] == {2'b00, ecc6({in_data[7:0], wc_lo_q, di_q})});
  assign last_word = (cnt_q == nwords_q - 15'd1);
  // A short packet that already completed (CHECK resolving to IDLE) is not
  // an interrupted packet.
  assign mid_pkt   = (state_q == ST_HDR1) || (act == ST_PAYLOAD) || (act == ST_CRC);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    di_d     = di_q;
    wc_lo_d  = wc_lo_q;
    nwords_d = nwords_q;
    cnt_d    = cnt_q;
    pix_en_d = pix_en_q;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    ls_d     = 1'b0;
    le_d     = 1'b0;
    pv_d     = 1'b0;
    pd_d     = pd_q;
    px_d     = px_q;
    ecc_d    = 1'b0;
    crc_d    = 1'b0;
    fmt_d    = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;

    if (rx_stop) begin
      state_d = ST_IDLE;
      fmt_d   = mid_pkt;
    end else if (pkt_start) begin
      state_d = ST_HDR0;
      fmt_d   = (act == ST_PAYLOAD) || (act == ST_CRC);
    end else begin
      state_d = act;
      if (in_valid) begin
        case (act)
          ST_HDR0: begin
            di_d    = in_data[7:0];
            wc_lo_d = in_data[15:8];
            state_d = ST_HDR1;
          end
          ST_HDR1: begin
            state_d  = ST_CHECK;
            tgt_d    = ST_IDLE;
            crc_clr  = 1'b1;
            cnt_d    = '0;
            nwords_d = hdr_wc[15:1];
            pix_en_d = (hdr_dt == RAW8_DT) && vc_ok;
            if (!ecc_ok) begin
              ecc_d = 1'b1;
            end else if (hdr_dt < DT_LONG_MIN) begin
              if (vc_ok) begin
                case (hdr_dt)
                  DT_FS:   fs_d = 1'b1;
                  DT_FE:   fe_d = 1'b1;
                  DT_LS:   ls_d = 1'b1;
                  DT_LE:   le_d = 1'b1;
                  default: ;
                endcase
              end
            end else if (hdr_wc[0] || (hdr_wc > MAX_WC_W)) begin
              fmt_d = 1'b1;
            end else begin
              tgt_d = (hdr_wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            crc_en = 1'b1;
            if (pix_en_q) begin
              pv_d = 1'b1;
              pd_d = in_data;
              px_d = {cnt_q[10:0], 1'b0};
              ls_d = (cnt_q == 15'd0);
              le_d = last_word;
            end
            cnt_d = cnt_q + 15'd1;
            if (last_word) state_d = ST_CRC;
          end
          ST_CRC: begin
            crc_d   = (in_data != crc_val);
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge mipi_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tgt_q    <= ST_IDLE;
      di_q     <= '0;
      wc_lo_q  <= '0;
      nwords_q <= '0;
      cnt_q    <= '0;
      pix_en_q <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      ls_q     <= 1'b0;
      le_q     <= 1'b0;
      pv_q     <= 1'b0;
      pd_q     <= '0;
      px_q     <= '0;
      ecc_q    <= 1'b0;
      crc_q    <= 1'b0;
      fmt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      di_q     <= di_d;
      wc_lo_q  <= wc_lo_d;
      nwords_q <= nwords_d;
      cnt_q    <= cnt_d;
      pix_en_q <= pix_en_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      ls_q     <= ls_d;
      le_q     <= le_d;
      pv_q     <= pv_d;
      pd_q     <= pd_d;
      px_q     <= px_d;
      ecc_q    <= ecc_d;
      crc_q    <= crc_d;
      fmt_q    <= fmt_d;
    end
  end

  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign line_start  = ls_q;
  assign line_end    = le_q;
  assign pix_valid   = pv_q;
  assign pix_data    = pd_q;
  assign pix_x       = px_q;
  assign ecc_err     = ecc_q;
  assign crc_err     = crc_q;
  assign fmt_err     = fmt_q;

endmodule

// File: tb/tb_csi_packet_decoder.sv
// Bench for csi_packet_decoder. Each packet task knows the packet it sends and
// books the outputs it must cause, keyed by the cycle they must appear in; a
// single negedge process compares every cycle's outputs against that booking
// (nothing booked = all outputs quiet).
module tb_csi_packet_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_stop = 1'b0, pkt_start = 1'b0, in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        frame_start, frame_end, line_start, line_end, pix_valid;
  logic [15:0] pix_data;
  logic [11:0] pix_x;
  logic        ecc_err, crc_err, fmt_err;

  csi_packet_decoder dut (
    .mipi_clk    (clk),
    .reset       (rst),
    .rx_stop     (rx_stop),
    .pkt_start   (pkt_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_start  (line_start),
    .line_end    (line_end),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .ecc_err     (ecc_err),
    .crc_err     (crc_err),
    .fmt_err     (fmt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        fs, fend, ls, le, pv;
    logic [15:0] pd;
    logic [11:0] px;
    logic        ecce, crce, fmte;
  } ev_t;

  ev_t         exp_a [int];
  logic [7:0]  pay_q [$];
  logic [15:0] pix_seen [$];
  logic [11:0] x_seen [$];
  int          ls_seen = 0;
  int          fs_seen = 0;

  // Syndrome column of each header bit D0..D23.
  logic [5:0] ecc_col [0:23] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                                 6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                                 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  function automatic logic [5:0] m_ecc(input logic [23:0] d);
    logic [5:0] s = '0;
    for (int i = 0; i < 24; i++) if (d[i]) s = s ^ ecc_col[i];
    return s;
  endfunction

  function automatic logic [15:0] m_crc(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        c = ((c[0] ^ pay_q[i][j]) != 1'b0) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input bit ps, input bit v, input logic [15:0] d, input bit st);
    pkt_start = ps;
    in_valid  = v;
    in_data   = d;
    rx_stop   = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0000, 0);
  endtask

  task automatic add_exp(input int k, input ev_t e);
    if (exp_a.exists(k)) exp_a[k] = ev_t'(exp_a[k] | e);
    else                 exp_a[k] = e;
  endtask

  task automatic fill_pay(input int n, input int seed);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'(seed + i * 7));
  endtask

  // abort_at: payload word index at which the packet is cut (-1 = none);
  // abort_ps selects pkt_start instead of rx_stop as the cause.
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input bit bad_ecc,
                          input bit bad_crc, input int abort_at, input bit abort_ps);
    ev_t         e;
    int          k, n;
    bit          pix, drop;
    logic [7:0]  ecc;
    logic [15:0] w, crc;
    ecc  = {2'b00, m_ecc({wc, di})} ^ (bad_ecc ? 8'h01 : 8'h00);
    drop = bad_ecc || (di[5:0] < 6'h10) || wc[0] || (wc > 16'd4096);
    drive(1, 0, 16'h0000, 0);
    drive(0, 1, {wc[7:0], di}, 0);
    k = cyc + 1;
    e = '0;
    if (bad_ecc) e.ecce = 1'b1;
    else if (di[5:0] < 6'h10) begin
      if (di[7:6] == 2'd0) begin
        e.fs   = (di[5:0] == 6'h00);
        e.fend = (di[5:0] == 6'h01);
        e.ls   = (di[5:0] == 6'h02);
        e.le   = (di[5:0] == 6'h03);
      end
    end else if (drop) e.fmte = 1'b1;
    add_exp(k, e);
    drive(0, 1, {ecc, wc[15:8]}, 0);
    if (drop) begin
      drive(0, 1, 16'hFFFF, 0);   // trailing word, must be ignored
      idle(2);
      return;
    end
    pix = (di == 8'h2A);
    n   = int'(wc) / 2;
    for (int i = 0; i < n; i++) begin
      k = cyc + 1;
      e = '0;
      w = {pay_q[2*i+1], pay_q[2*i]};
      if (i == abort_at) begin
        e.fmte = 1'b1;
        add_exp(k, e);
        if (abort_ps) drive(1, 0, 16'h0000, 0);
        else          drive(0, 1, w, 1);
        return;
      end
      if (pix) begin
        e.pv = 1'b1;
        e.pd = w;
        e.px = 12'(2 * i);
        e.ls = (i == 0);
        e.le = (i == n - 1);
      end
      add_exp(k, e);
      drive(0, 1, w, 0);
    end
    crc = m_crc(n * 2);
    k = cyc + 1;
    e = '0;
    e.crce = bad_crc;
    add_exp(k, e);
    drive(0, 1, crc ^ (bad_crc ? 16'h0100 : 16'h0000), 0);
    idle(2);
  endtask

  always @(negedge clk) begin
    ev_t a, x;
    a = {frame_start, frame_end, line_start, line_end, pix_valid, pix_data, pix_x,
         ecc_err, crc_err, fmt_err};
    x = exp_a.exists(cyc) ? exp_a[cyc] : ev_t'('0);
    if (!x.pv) begin
      a.pd = '0;
      a.px = '0;
    end
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, a, x);
    end
    if (pix_valid === 1'b1) begin
      pix_seen.push_back(pix_data);
      x_seen.push_back(pix_x);
    end
    if (line_start === 1'b1)  ls_seen++;
    if (frame_start === 1'b1) fs_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ls0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {16'h0, frame_start, frame_end, line_start, line_end, pix_valid,
        ecc_err, crc_err, fmt_err, pix_data[7:0]}, 32'h0);
    chk("reset_pix", {4'h0, pix_x, pix_data}, 32'h0);
    rst = 1'b0;
    idle(2);

    // Pin the bench's own ECC/CRC model to hand-derived values.
    chk("ecc_zero", 32'(m_ecc(24'h000000)), 32'h00);
    chk("ecc_d0", 32'(m_ecc(24'h000001)), 32'h07);
    chk("ecc_raw8_wc4", 32'(m_ecc(24'h00042A)), 32'h33);
    pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_check_value", 32'(m_crc(9)), 32'h6F91);

    // FS, then FS with corrupted ECC, then FE to show the FSM recovered.
    send_pkt(8'h00, 16'd0, 0, 0, -1, 0);
    chk("fs_count_good", fs_seen, 1);
    send_pkt(8'h00, 16'd0, 1, 0, -1, 0);
    chk("fs_count_badecc", fs_seen, 1);
    send_pkt(8'h01, 16'd0, 0, 0, -1, 0);

    // RAW8 line, WC=4, good CRC then corrupted CRC.
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    pix_seen.delete(); x_seen.delete();
    send_pkt(8'h2A, 16'd4, 0, 0, -1, 0);
    chk("raw8_npix", pix_seen.size(), 2);
    chk("raw8_pix0", {x_seen[0], pix_seen[0]}, {4'h0, 12'd0, 16'h2211});
    chk("raw8_pix1", {x_seen[1], pix_seen[1]}, {4'h0, 12'd2, 16'h4433});
    pix_seen.delete(); x_seen.delete();
    send_pkt(8'h2A, 16'd4, 0, 1, -1, 0);
    chk("badcrc_npix", pix_seen.size(), 2);
    chk("badcrc_pix1", {x_seen[1], pix_seen[1]}, {4'h0, 12'd2, 16'h4433});

    // Odd WC, WC above limit, WC=0, WC=2.
    fill_pay(8, 3);
    send_pkt(8'h2A, 16'd3, 0, 0, -1, 0);
    send_pkt(8'h2A, 16'd4098, 0, 0, -1, 0);
    send_pkt(8'h2A, 16'd0, 0, 0, -1, 0);
    send_pkt(8'h2A, 16'd2, 0, 0, -1, 0);

    // WC=8 cut by rx_stop after two words; then cut by pkt_start.
    pix_seen.delete(); x_seen.delete();
    send_pkt(8'h2A, 16'd8, 0, 0, 2, 0);
    chk("stop_npix", pix_seen.size(), 2);
    idle(2);
    send_pkt(8'h2A, 16'd8, 0, 0, 1, 1);
    send_pkt(8'h03, 16'd0, 0, 0, -1, 0);

    // rx_stop while idle is harmless.
    drive(0, 0, 16'h0000, 1);
    idle(2);

    // Other VC is consumed silently; following VC0 LS still strobes.
    ls0 = ls_seen;
    pix_seen.delete(); x_seen.delete();
    fill_pay(4, 9);
    send_pkt(8'h6A, 16'd4, 0, 0, -1, 0);
    chk("vc1_ls", ls_seen, ls0);
    chk("vc1_npix", pix_seen.size(), 0);
    send_pkt(8'h02, 16'd0, 0, 0, -1, 0);
    chk("vc0_ls", ls_seen, ls0 + 1);

    // Non-RAW8 long type and the largest accepted line.
    fill_pay(6, 5);
    send_pkt(8'h2B, 16'd6, 0, 0, -1, 0);
    fill_pay(4096, 1);
    pix_seen.delete(); x_seen.delete();
    send_pkt(8'h2A, 16'd4096, 0, 0, -1, 0);
    chk("maxwc_npix", pix_seen.size(), 2048);
    chk("maxwc_lastx", 32'(x_seen[2047]), 32'd4094);

    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
